// File: rtl/ak4619_cal.sv
// Per-channel offset/gain calibration for the AK4619 sample stream: one shared
// multiplier, four channels issued back to back, all outputs updated together.
module ak4619_cal #(
  parameter int W    = 16,
  parameter int N_CH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] in0,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic                cal_we,
  input  logic [2:0]          cal_addr,
  input  logic signed [W-1:0] cal_data,
  input  logic                clip_clr,
  output logic signed [W-1:0] out0,
  output logic signed [W-1:0] out1,
  output logic signed [W-1:0] out2,
  output logic signed [W-1:0] out3,
  output logic                out_valid,
  output logic [N_CH-1:0]     clip,
  output logic                overrun
);

  localparam int CW = $clog2(N_CH);
  localparam int DW = W + 1;
  localparam int PW = 2 * W + 1;
  localparam int SH = W - 2;
  localparam int SW = PW - SH;
  localparam logic signed [W-1:0] UNITY = {2'b01, {(W-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic ovf(input logic signed [SW-1:0] v);
    return !((v[SW-1:W-1] == '0) || (v[SW-1:W-1] == '1));
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
    if (!ovf(v))     return v[W-1:0];
    else if (v[SW-1]) return {1'b1, {(W-1){1'b0}}};
    else              return {1'b0, {(W-1){1'b1}}};
  endfunction

  state_t               r_state, w_state_nxt;
  logic                 r_sclk_d;
  logic                 w_edge, w_start, w_issue;
  logic [CW-1:0]        r_idx;
  logic signed [W-1:0]  r_live_off [N_CH];
  logic signed [W-1:0]  r_live_gain[N_CH];
  logic signed [W-1:0]  r_snap_off [N_CH];
  logic signed [W-1:0]  r_snap_gain[N_CH];
  logic signed [W-1:0]  r_frame    [N_CH];
  logic signed [W-1:0]  r_shadow   [N_CH];
  logic signed [W-1:0]  r_out      [N_CH];
  logic                 r_vld_p1, r_vld_p2, r_done_p3;
  logic [CW-1:0]        r_ch_p1, r_ch_p2;
  logic signed [DW-1:0] r_diff_p1;
  logic signed [W-1:0]  r_gain_p1;
  logic signed [SW-1:0] r_sh_p2;
  logic signed [PW-1:0] w_prod;
  logic [N_CH-1:0]      r_clip, w_clip_set;
  logic                 r_out_valid, r_overrun;

  assign w_edge = sample_clk & ~r_sclk_d;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: if (w_edge) begin
        w_start     = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_issue = 1'b1;
        if (r_idx == CW'(N_CH - 1)) w_state_nxt = DRAIN;
      end
      DRAIN: if (!r_vld_p1 && !r_vld_p2 && !r_done_p3) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sclk_d  <= 1'b0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sclk_d <= sample_clk;
      if (w_start)      r_idx <= '0;
      else if (w_issue) r_idx <= r_idx + 1'b1;
      // An edge outside IDLE is dropped; the frame in flight is left alone.
      if (w_edge && r_state != IDLE) r_overrun <= 1'b1;
    end
  end

  // Live coefficients, frame buffer and per-frame coefficient snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_live_off[i]  <= '0;
        r_live_gain[i] <= UNITY;
        r_snap_off[i]  <= '0;
        r_snap_gain[i] <= UNITY;
        r_frame[i]     <= '0;
      end
    end else begin
      if (cal_we) begin
        if (cal_addr[2]) r_live_gain[cal_addr[1:0]] <= cal_data;
        else             r_live_off[cal_addr[1:0]]  <= cal_data;
      end
      if (w_start) begin
        r_frame[0] <= in0;
        r_frame[1] <= in1;
        r_frame[2] <= in2;
        r_frame[3] <= in3;
        for (int i = 0; i < N_CH; i++) begin
          r_snap_off[i]  <= r_live_off[i];
          r_snap_gain[i] <= r_live_gain[i];
        end
      end
    end
  end

  assign w_prod = PW'(r_diff_p1) * PW'(r_gain_p1);

  always_comb begin
    w_clip_set = '0;
    if (r_vld_p2 && ovf(r_sh_p2)) w_clip_set[r_ch_p2] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_ch_p1     <= '0;
      r_diff_p1   <= '0;
      r_gain_p1   <= '0;
      r_vld_p2    <= 1'b0;
      r_ch_p2     <= '0;
      r_sh_p2     <= '0;
      r_done_p3   <= 1'b0;
      r_out_valid <= 1'b0;
      r_clip      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= '0;
        r_out[i]    <= '0;
      end
    end else begin
      // Stage 1: offset subtraction
      r_vld_p1  <= w_issue;
      r_ch_p1   <= r_idx;
      r_diff_p1 <= DW'(r_frame[r_idx]) - DW'(r_snap_off[r_idx]);
      r_gain_p1 <= r_snap_gain[r_idx];
      // Stage 2: gain multiply, floor shift back to sample scale
      r_vld_p2  <= r_vld_p1;
      r_ch_p2   <= r_ch_p1;
      r_sh_p2   <= SW'(w_prod >>> SH);
      // Stage 3: saturate into shadow
      if (r_vld_p2) r_shadow[r_ch_p2] <= sat_w(r_sh_p2);
      r_done_p3 <= r_vld_p2 && (r_ch_p2 == CW'(N_CH - 1));
      r_clip    <= (r_clip & ~{N_CH{clip_clr}}) | w_clip_set;
      // Output stage: all channels update together
      r_out_valid <= r_done_p3;
      if (r_done_p3) begin
        for (int i = 0; i < N_CH; i++) r_out[i] <= r_shadow[i];
      end
    end
  end

  assign out0      = r_out[0];
  assign out1      = r_out[1];
  assign out2      = r_out[2];
  assign out3      = r_out[3];
  assign out_valid = r_out_valid;
  assign clip      = r_clip;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ak4619_cal.sv
// Directed bench for ak4619_cal: calibration math, saturation, snapshot timing,
// overrun and mid-frame reset.
module tb_ak4619_cal;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_clk = 1'b0;
  logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic               cal_we = 1'b0;
  logic [2:0]         cal_addr = '0;
  logic signed [15:0] cal_data = '0;
  logic               clip_clr = 1'b0;
  logic signed [15:0] out0, out1, out2, out3;
  logic               out_valid;
  logic [3:0]         clip;
  logic               overrun;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_pulse = 0, pulse_at = 0;

  ak4619_cal #(.W(16), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .cal_we(cal_we), .cal_addr(cal_addr), .cal_data(cal_data),
    .clip_clr(clip_clr),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input int d);
    @(negedge clk);
    cal_we = 1'b1; cal_addr = a; cal_data = 16'(d);
    @(negedge clk);
    cal_we = 1'b0;
  endtask

  task automatic launch(input int a, input int b, input int c, input int d);
    @(negedge clk);
    in0 = 16'(a); in1 = 16'(b); in2 = 16'(c); in3 = 16'(d);
    sample_clk = 1'b1;
    @(posedge clk);
    #1 sample_clk = 1'b0;
    cyc = 0; n_pulse = 0; pulse_at = 0;
  endtask

  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 cyc++;
      if (out_valid) begin
        n_pulse++;
        pulse_at = cyc;
      end
    end
  endtask

  task automatic chk_outs(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_pulses"}, n_pulse, 1);
    chk({tag, "_lat"}, pulse_at, 7);
    chk({tag, "_out0"}, out0, a);
    chk({tag, "_out1"}, out1, b);
    chk({tag, "_out2"}, out2, c);
    chk({tag, "_out3"}, out3, d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out0", out0, 0);
    chk("rst_out3", out3, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);

    // Unity defaults pass samples through
    launch(1000, -1000, 0, 32767);
    watch(12);
    chk_outs("unity", 1000, -1000, 0, 32767);
    chk("unity_clip", clip, 0);

    // Offset on ch0, half gain on ch1 (floor rounding)
    wr(3'b000, 100);
    wr(3'b101, 8192);
    launch(1000, -1001, 1234, -5678);
    watch(12);
    chk_outs("cal", 900, -501, 1234, -5678);

    // Saturation both directions
    wr(3'b110, 32767);
    wr(3'b011, 1);
    launch(1000, -1001, 30000, -32768);
    watch(12);
    chk_outs("sat", 900, -501, 32767, -32768);
    chk("sat_clip", clip, 4'b1100);

    @(negedge clk) clip_clr = 1'b1;
    @(negedge clk) clip_clr = 1'b0;
    chk("clip_clr", clip, 0);

    // Write offset0 mid-frame: snapshot keeps the old value
    launch(1000, 0, 0, 0);
    watch(1);
    cal_we = 1'b1; cal_addr = 3'b000; cal_data = 16'sd500;
    watch(1);
    cal_we = 1'b0;
    watch(10);
    chk_outs("snap_old", 900, 0, 0, -1);
    chk("snap_clip", clip, 0);
    launch(1000, 0, 0, 0);
    watch(12);
    chk_outs("snap_new", 500, 0, 0, -1);

    // Second frame edge while busy
    launch(2000, 0, 0, 0);
    watch(2);
    sample_clk = 1'b1;
    watch(1);
    sample_clk = 1'b0;
    watch(9);
    chk_outs("ovr", 1500, 0, 0, -1);
    chk("ovr_flag", overrun, 1);

    // Reset mid-frame
    launch(5, 6, 7, 8);
    watch(3);
    #2 rst = 1'b1;
    #1;
    chk("mrst_out0", out0, 0);
    chk("mrst_out1", out1, 0);
    chk("mrst_out3", out3, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_overrun", overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    n_pulse = 0;
    watch(10);
    chk("mrst_nopulse", n_pulse, 0);

    // Coefficients are back at defaults
    launch(1000, -1000, 0, 32767);
    watch(12);
    chk_outs("post", 1000, -1000, 0, 32767);
    chk("post_clip", clip, 0);
    chk("post_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
